// File: rtl/complement_accumulator_pkg.sv
// Shared definitions for the complement accumulator: FSM encoding, default
// geometry and the signed saturation bounds derived from the accumulator width.
package complement_accumulator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam int DATA_W_DEF  = 4;
   localparam int ACC_W_DEF   = 8;
   localparam int COUNT_N_DEF = 16;

   // Largest and smallest values representable in an acc_w-bit two's-complement word.
   function automatic int acc_max_of(input int acc_w);
      return (1 << (acc_w - 1)) - 1;
   endfunction

   function automatic int acc_min_of(input int acc_w);
      return -acc_max_of(acc_w) - 1;
   endfunction

   localparam int ACC_MAX = acc_max_of(ACC_W_DEF);
   localparam int ACC_MIN = acc_min_of(ACC_W_DEF);

endpackage : complement_accumulator_pkg

// File: rtl/complement_accumulator_sat_add.sv
// Combinational signed add of a sign-extended DATA_W word into an ACC_W
// accumulator, clamped to the accumulator range with a saturation flag.
module complement_accumulator_sat_add
   import complement_accumulator_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic signed [ACC_W-1:0]  acc,
   input  logic signed [DATA_W-1:0] addend,
   output logic signed [ACC_W-1:0]  sum,
   output logic                     sat
);

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(acc_max_of(ACC_W));
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(acc_min_of(ACC_W));

   logic signed [ACC_W:0] wide;

   always_comb begin
      wide = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - DATA_W){addend[DATA_W-1]}}, addend};
      // The ACC_W+1-bit sum leaves the ACC_W range exactly when its top two bits differ.
      sat  = wide[ACC_W] ^ wide[ACC_W-1];
      if (!sat) begin
         sum = wide[ACC_W-1:0];
      end else if (wide[ACC_W]) begin
         sum = SAT_MIN;
      end else begin
         sum = SAT_MAX;
      end
   end

endmodule : complement_accumulator_sat_add

// File: rtl/complement_accumulator.sv
// Saturating signed accumulator over COUNT_N handshaked two's-complement words;
// holds the result with done high until re-armed by start or aborted by clear.
module complement_accumulator
   import complement_accumulator_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ACC_W   = ACC_W_DEF,
   parameter int COUNT_N = COUNT_N_DEF
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic                             clear,
   input  logic                             in_valid,
   input  logic signed [DATA_W-1:0]         in_data,
   output logic                             in_ready,
   output logic signed [ACC_W-1:0]          acc_out,
   output logic [$clog2(COUNT_N+1)-1:0]     sample_cnt,
   output logic                             overflow,
   output logic                             done
);

   localparam int CNT_W = $clog2(COUNT_N + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT_N - 1);

   if (ACC_W < DATA_W) begin : g_bad_acc_w
      $error("complement_accumulator: ACC_W must be >= DATA_W");
   end
   if (COUNT_N < 1) begin : g_bad_count_n
      $error("complement_accumulator: COUNT_N must be >= 1");
   end

   state_e                   state_q, state_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     ovf_q, ovf_d;
   logic signed [ACC_W-1:0]  add_sum;
   logic                     add_sat;

   complement_accumulator_sat_add #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_sat_add (
      .acc    (acc_q),
      .addend (in_data),
      .sum    (add_sum),
      .sat    (add_sat)
   );

   // NOTE: every variable gets its hold value first so no path through the
   // case leaves one unassigned; that is what keeps this block latch-free.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;

      if (clear) begin
         state_d = ST_IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_d = ST_ACCUM;
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
               end
            end
            ST_ACCUM: begin
               // in_ready is implied by the state, so in_valid alone is the handshake here.
               if (in_valid) begin
                  acc_d = add_sum;
                  ovf_d = ovf_q | add_sat;
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_CNT) begin
                     state_d = ST_DONE;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready   = (state_q == ST_ACCUM);
   assign done       = (state_q == ST_DONE);
   assign acc_out    = acc_q;
   assign sample_cnt = cnt_q;
   assign overflow   = ovf_q;

endmodule : complement_accumulator

// File: tb/tb_complement_accumulator.sv
// Two accumulators (8-bit and 6-bit wide) share one stimulus stream and are
// compared every cycle against an arithmetic model of the run/sum rules.
module tb_complement_accumulator;

   localparam int N = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       clear = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] in_data = 4'h0;

   logic              rdy_a, ovf_a, done_a;
   logic signed [7:0] acc_a;
   logic [4:0]        cnt_a;
   logic              rdy_b, ovf_b, done_b;
   logic signed [5:0] acc_b;
   logic [4:0]        cnt_b;

   always #5 clk = ~clk;

   complement_accumulator #(.DATA_W(4), .ACC_W(8), .COUNT_N(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
      .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_a),
      .acc_out(acc_a), .sample_cnt(cnt_a), .overflow(ovf_a), .done(done_a)
   );

   complement_accumulator #(.DATA_W(4), .ACC_W(6), .COUNT_N(N)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
      .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_b),
      .acc_out(acc_b), .sample_cnt(cnt_b), .overflow(ovf_b), .done(done_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic signed [31:0] actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Reference model: index 0 is the 8-bit instance, index 1 the 6-bit one.
   int m_w[2] = '{8, 6};
   int m_acc[2];
   int m_cnt[2];
   bit m_ovf[2];
   bit m_run[2];
   bit m_fin[2];

   function automatic int sx(input logic [3:0] d);
      return d[3] ? int'(d) - 16 : int'(d);
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_run[k] = 0; m_fin[k] = 0;
      end
   endfunction

   function automatic void model_edge();
      for (int k = 0; k < 2; k++) begin
         int hi = (1 << (m_w[k] - 1)) - 1;
         int lo = -(1 << (m_w[k] - 1));
         if (clear) begin
            m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_run[k] = 0; m_fin[k] = 0;
         end else if (!m_run[k]) begin
            if (start) begin
               m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_run[k] = 1; m_fin[k] = 0;
            end
         end else if (in_valid) begin
            int s = m_acc[k] + sx(in_data);
            if (s > hi) begin
               m_acc[k] = hi; m_ovf[k] = 1;
            end else if (s < lo) begin
               m_acc[k] = lo; m_ovf[k] = 1;
            end else begin
               m_acc[k] = s;
            end
            m_cnt[k]++;
            if (m_cnt[k] == N) begin
               m_run[k] = 0; m_fin[k] = 1;
            end
         end
      end
   endfunction

   task automatic compare_all(input string tag);
      check({tag, "/acc_a"},  acc_a,  m_acc[0]);
      check({tag, "/cnt_a"},  cnt_a,  m_cnt[0]);
      check({tag, "/ovf_a"},  ovf_a,  int'(m_ovf[0]));
      check({tag, "/done_a"}, done_a, int'(m_fin[0]));
      check({tag, "/rdy_a"},  rdy_a,  int'(m_run[0]));
      check({tag, "/acc_b"},  acc_b,  m_acc[1]);
      check({tag, "/cnt_b"},  cnt_b,  m_cnt[1]);
      check({tag, "/ovf_b"},  ovf_b,  int'(m_ovf[1]));
      check({tag, "/done_b"}, done_b, int'(m_fin[1]));
      check({tag, "/rdy_b"},  rdy_b,  int'(m_run[1]));
   endtask

   // Apply one cycle of inputs, advance the model on the edge, compare mid-cycle.
   task automatic drive(input string tag, input bit st, input bit cl, input bit v, input logic [3:0] d);
      start = st; clear = cl; in_valid = v; in_data = d;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all(tag);
   endtask

   task automatic run_ramp(input string tag);
      drive({tag, "_start"}, 1'b1, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 16; i++) drive(tag, 1'b0, 1'b0, 1'b1, 4'(i));
      drive({tag, "_hold"}, 1'b0, 1'b0, 1'b1, 4'h3);
      check({tag, "_final_acc"},  acc_a,  -8);
      check({tag, "_final_cnt"},  cnt_a,  16);
      check({tag, "_final_done"}, done_a, 1);
      check({tag, "_final_rdy"},  rdy_a,  0);
      check({tag, "_final_ovf"},  ovf_a,  0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      #1 rst_n = 1'b0;
      @(negedge clk);
      compare_all("reset");
      rst_n = 1'b1;

      // Valid data before any start must be ignored.
      for (int i = 0; i < 10; i++) drive("idle_valid", 1'b0, 1'b0, 1'b1, 4'b0101);

      run_ramp("ramp");

      // Positive saturation on the 6-bit instance, then finish the run.
      drive("sat_start", 1'b1, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 5; i++) drive("sat_pos", 1'b0, 1'b0, 1'b1, 4'b0111);
      check("sat_pos_acc_b", acc_b, 31);
      check("sat_pos_ovf_b", ovf_b, 1);
      check("sat_pos_acc_a", acc_a, 35);
      for (int i = 0; i < 11; i++) drive("sat_fill", 1'b0, 1'b0, 1'b1, 4'($urandom));

      // Negative saturation on 6 bits; exactly the minimum on 8 bits.
      drive("neg_start", 1'b1, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 16; i++) drive("sat_neg", 1'b0, 1'b0, 1'b1, 4'b1000);
      check("sat_neg_acc_b", acc_b, -32);
      check("sat_neg_ovf_b", ovf_b, 1);
      check("sat_neg_acc_a", acc_a, -128);
      check("sat_neg_ovf_a", ovf_a, 0);

      // Gapped valid with a fixed leading pattern, then random gaps to completion.
      drive("gap_start", 1'b1, 1'b0, 1'b0, 4'h0);
      begin
         logic [3:0] pat [4] = '{4'b0011, 4'b1111, 4'b0010, 4'b1110};
         for (int i = 0; i < 4; i++) begin
            drive("gap_idle", 1'b0, 1'b0, 1'b0, 4'($urandom));
            drive("gap_word", 1'b0, 1'b0, 1'b1, pat[i]);
         end
      end
      check("gap_acc", acc_a, 2);
      check("gap_cnt", cnt_a, 4);
      begin
         int budget = 0;
         while (!(done_a && done_b) && budget < 80) begin
            drive("gap_rand", 1'b0, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom));
            budget++;
         end
      end
      check("gap_done_reached", done_a, 1);

      // Clear and start together mid-run: clear wins.
      drive("col_start", 1'b1, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 3; i++) drive("col_feed", 1'b0, 1'b0, 1'b1, 4'b0010);
      check("col_acc_before", acc_a, 6);
      drive("col_hit", 1'b1, 1'b1, 1'b1, 4'b0101);
      check("col_acc_after", acc_a, 0);
      check("col_cnt_after", cnt_a, 0);
      check("col_rdy_after", rdy_a, 0);
      drive("col_idle", 1'b0, 1'b0, 1'b1, 4'b0101);

      // Random traffic with occasional start/clear.
      for (int i = 0; i < 400; i++) begin
         drive("random", 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 29) == 0),
               1'($urandom_range(0, 3) != 0), 4'($urandom));
      end

      // Asynchronous reset between edges mid-run.
      drive("rst_clear", 1'b0, 1'b1, 1'b0, 4'h0);
      drive("rst_start", 1'b1, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 5; i++) drive("rst_feed", 1'b0, 1'b0, 1'b1, 4'($urandom));
      #2 rst_n = 1'b0;
      model_reset();
      #1 compare_all("async_rst");
      check("async_rst_acc", acc_a, 0);
      @(negedge clk);
      compare_all("rst_held");
      rst_n = 1'b1;
      run_ramp("ramp2");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_complement_accumulator
